logic16_arbiter: RTL and testbench

Round-robin arbiter and sequencer that shares a single 16-bit bitwise logic unit between two requesters. The unit supports OR, AND, XOR and NOT. The block accepts one operation at a time over a valid/ready handshake, registers the operands, computes the result, and returns it to the issuing requester as a one-cycle response pulse. It sits between the requester ports (CPU-side control, DMA-side control) and the shared 16-bit gate-level logic datapath.

---
 rtl/logic16_arbiter.sv | 141 ++++++++++++++
 tb/tb_logic16_arbiter.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/logic16_arbiter.sv
// Round-robin arbiter and sequencer sharing one 16-bit bitwise logic unit
// (OR/AND/XOR/NOT) between two requesters over a valid/ready handshake.

module logic16_unit #(
  parameter int WIDTH = 16
) (
  input  logic [1:0]       i_op,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  output logic [WIDTH-1:0] o_y
);

  // Independent per-bit slices: every opcode is purely bitwise, so no carries.
  for (genvar gBit = 0; gBit < WIDTH; gBit++) begin : gSlice
    logic w_or;
    logic w_and;
    logic w_xor;
    logic w_not;

    assign w_or  = i_a[gBit] | i_b[gBit];
    assign w_and = i_a[gBit] & i_b[gBit];
    assign w_xor = i_a[gBit] ^ i_b[gBit];
    assign w_not = ~i_a[gBit];

    always_comb begin
      unique case (i_op)
        2'b00:   o_y[gBit] = w_or;
        2'b01:   o_y[gBit] = w_and;
        2'b10:   o_y[gBit] = w_xor;
        default: o_y[gBit] = w_not;
      endcase
    end
  end

endmodule

module logic16_arbiter #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req0_valid,
  input  logic [1:0]       req0_op,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  output logic             req0_ready,
  input  logic             req1_valid,
  input  logic [1:0]       req1_op,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  output logic             req1_ready,
  output logic             rsp0_valid,
  output logic             rsp1_valid,
  output logic [WIDTH-1:0] rsp_data,
  output logic             busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_nextState;
  logic             r_lastGrant;
  logic             r_owner;
  logic [1:0]       r_op;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_rspData;

  logic             w_grant0;
  logic             w_grant1;
  logic             w_transfer;
  logic [WIDTH-1:0] w_result;

  // On a tie the requester that did not win last time is granted.
  assign w_grant0 = req0_valid & (~req1_valid | r_lastGrant);
  assign w_grant1 = req1_valid & (~req0_valid | ~r_lastGrant);

  assign req0_ready = (r_state == IDLE) & w_grant0;
  assign req1_ready = (r_state == IDLE) & w_grant1;
  assign w_transfer = req0_ready | req1_ready;

  logic16_unit #(.WIDTH(WIDTH)) uUnit (
    .i_op (r_op),
    .i_a  (r_a),
    .i_b  (r_b),
    .o_y  (w_result)
  );

  always_comb begin
    w_nextState = r_state;
    unique case (r_state)
      IDLE:    if (w_transfer) w_nextState = EXEC;
      EXEC:    w_nextState = RESP;
      RESP:    w_nextState = IDLE;
      default: w_nextState = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_lastGrant <= 1'b1;
      r_owner     <= 1'b0;
      r_op        <= 2'b00;
      r_a         <= '0;
      r_b         <= '0;
    end else if (w_transfer) begin
      r_lastGrant <= req1_ready;
      r_owner     <= req1_ready;
      r_op        <= req1_ready ? req1_op : req0_op;
      r_a         <= req1_ready ? req1_a  : req0_a;
      r_b         <= req1_ready ? req1_b  : req0_b;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rspData <= '0;
    end else if (r_state == EXEC) begin
      r_rspData <= w_result;
    end
  end

  // Responses decode straight from state so a reset kills any pulse at once.
  assign rsp0_valid = (r_state == RESP) & ~r_owner;
  assign rsp1_valid = (r_state == RESP) &  r_owner;
  assign rsp_data   = r_rspData;
  assign busy       = (r_state != IDLE);

endmodule

// File: tb/tb_logic16_arbiter.sv
// Directed self-checking bench for logic16_arbiter: single ops, all opcodes,
// contention, single-requester fairness, reset mid-operation and withdrawal.

module tb_logic16_arbiter;

  logic        clk;
  logic        reset;
  logic        req0_valid;
  logic [1:0]  req0_op;
  logic [15:0] req0_a;
  logic [15:0] req0_b;
  logic        req0_ready;
  logic        req1_valid;
  logic [1:0]  req1_op;
  logic [15:0] req1_a;
  logic [15:0] req1_b;
  logic        req1_ready;
  logic        rsp0_valid;
  logic        rsp1_valid;
  logic [15:0] rsp_data;
  logic        busy;

  int checkCount;
  int failCount;

  logic16_arbiter #(.WIDTH(16)) dut (
    .clk        (clk),
    .reset      (reset),
    .req0_valid (req0_valid),
    .req0_op    (req0_op),
    .req0_a     (req0_a),
    .req0_b     (req0_b),
    .req0_ready (req0_ready),
    .req1_valid (req1_valid),
    .req1_op    (req1_op),
    .req1_a     (req1_a),
    .req1_b     (req1_b),
    .req1_ready (req1_ready),
    .rsp0_valid (rsp0_valid),
    .rsp1_valid (rsp1_valid),
    .rsp_data   (rsp_data),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, observed, expected, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input int who, input logic valid, input logic [1:0] op,
                               input logic [15:0] a, input logic [15:0] b);
    if (who == 0) begin
      req0_valid = valid; req0_op = op; req0_a = a; req0_b = b;
    end else begin
      req1_valid = valid; req1_op = op; req1_a = a; req1_b = b;
    end
  endtask

  task automatic doReset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  // One complete transaction from a single requester, checking every phase.
  task automatic runOp(input string tag, input int who, input logic [1:0] op,
                       input logic [15:0] a, input logic [15:0] b, input logic [15:0] expData);
    applyStimulus(who, 1'b1, op, a, b);
    #1;
    checkOutput({tag, ".ready0"}, 32'(req0_ready), 32'(who == 0));
    checkOutput({tag, ".ready1"}, 32'(req1_ready), 32'(who == 1));
    tick();
    applyStimulus(who, 1'b0, op, a, b);
    checkOutput({tag, ".execBusy"}, 32'(busy), 32'd1);
    checkOutput({tag, ".execRsp"}, 32'({rsp1_valid, rsp0_valid}), 32'd0);
    tick();
    checkOutput({tag, ".rsp0"}, 32'(rsp0_valid), 32'(who == 0));
    checkOutput({tag, ".rsp1"}, 32'(rsp1_valid), 32'(who == 1));
    checkOutput({tag, ".data"}, 32'(rsp_data), 32'(expData));
    tick();
    checkOutput({tag, ".idleBusy"}, 32'(busy), 32'd0);
    checkOutput({tag, ".idleRsp"}, 32'({rsp1_valid, rsp0_valid}), 32'd0);
    checkOutput({tag, ".hold"}, 32'(rsp_data), 32'(expData));
  endtask

  initial begin
    checkCount = 0;
    failCount  = 0;
    reset = 1'b1;
    applyStimulus(0, 1'b0, 2'b00, 16'h0000, 16'h0000);
    applyStimulus(1, 1'b0, 2'b00, 16'h0000, 16'h0000);
    tick();

    // Reset values, and ready follows arbitration while still in reset.
    checkOutput("rst.busy", 32'(busy), 32'd0);
    checkOutput("rst.data", 32'(rsp_data), 32'd0);
    checkOutput("rst.rsp", 32'({rsp1_valid, rsp0_valid}), 32'd0);
    checkOutput("rst.readyNone", 32'({req1_ready, req0_ready}), 32'd0);
    applyStimulus(0, 1'b1, 2'b00, 16'h00F0, 16'h0F00);
    #1;
    checkOutput("rst.ready0", 32'(req0_ready), 32'd1);
    tick();
    reset = 1'b0;

    runOp("single", 0, 2'b00, 16'h00F0, 16'h0F00, 16'h0FF0);

    runOp("and1", 1, 2'b01, 16'hAAAA, 16'h0FF0, 16'h0AA0);
    runOp("xor1", 1, 2'b10, 16'hAAAA, 16'h0FF0, 16'hA55A);
    runOp("not1", 1, 2'b11, 16'hAAAA, 16'h0FF0, 16'h5555);
    runOp("notB", 1, 2'b11, 16'hAAAA, 16'hFFFF, 16'h5555);

    // Contention from reset: both valid held, grants alternate 0,1,0,1.
    doReset();
    applyStimulus(0, 1'b1, 2'b00, 16'h1200, 16'h0034);
    applyStimulus(1, 1'b1, 2'b10, 16'hFFFF, 16'h00FF);
    for (int i = 0; i < 4; i++) begin
      #1;
      checkOutput($sformatf("cont%0d.ready0", i), 32'(req0_ready), 32'(i % 2 == 0));
      checkOutput($sformatf("cont%0d.ready1", i), 32'(req1_ready), 32'(i % 2 == 1));
      tick();
      checkOutput($sformatf("cont%0d.readyBusy", i), 32'({req1_ready, req0_ready}), 32'd0);
      tick();
      checkOutput($sformatf("cont%0d.rsp0", i), 32'(rsp0_valid), 32'(i % 2 == 0));
      checkOutput($sformatf("cont%0d.rsp1", i), 32'(rsp1_valid), 32'(i % 2 == 1));
      checkOutput($sformatf("cont%0d.data", i), 32'(rsp_data),
                  (i % 2 == 0) ? 32'h1234 : 32'hFF00);
      tick();
    end
    applyStimulus(0, 1'b0, 2'b00, 16'h0000, 16'h0000);
    applyStimulus(1, 1'b0, 2'b00, 16'h0000, 16'h0000);
    tick();

    // Only requester 1 active: granted every time, even though it won last.
    runOp("solo0", 1, 2'b01, 16'hF0F0, 16'hFF00, 16'hF000);
    runOp("solo1", 1, 2'b00, 16'h0001, 16'h8000, 16'h8001);
    runOp("solo2", 1, 2'b10, 16'h1234, 16'h1234, 16'h0000);

    // Reset during EXEC drops the operation and clears rsp_data at once.
    runOp("pre", 0, 2'b00, 16'h0C00, 16'h0003, 16'h0C03);
    applyStimulus(0, 1'b1, 2'b00, 16'hFFFF, 16'h0000);
    tick();
    applyStimulus(0, 1'b0, 2'b00, 16'hFFFF, 16'h0000);
    checkOutput("rstExec.busyBefore", 32'(busy), 32'd1);
    reset = 1'b1;
    #1;
    checkOutput("rstExec.busy", 32'(busy), 32'd0);
    checkOutput("rstExec.data", 32'(rsp_data), 32'd0);
    checkOutput("rstExec.rsp", 32'({rsp1_valid, rsp0_valid}), 32'd0);
    tick();
    checkOutput("rstExec.rspLater", 32'({rsp1_valid, rsp0_valid}), 32'd0);
    reset = 1'b0;
    runOp("post", 0, 2'b01, 16'h00FF, 16'h0F0F, 16'h000F);

    // Requester 1 raises valid while busy, then withdraws before IDLE.
    applyStimulus(0, 1'b1, 2'b10, 16'h00FF, 16'hFFFF);
    #1;
    checkOutput("wd.ready0", 32'(req0_ready), 32'd1);
    tick();
    applyStimulus(0, 1'b0, 2'b10, 16'h00FF, 16'hFFFF);
    applyStimulus(1, 1'b1, 2'b00, 16'h1111, 16'h2222);
    #1;
    checkOutput("wd.execReady1", 32'(req1_ready), 32'd0);
    tick();
    checkOutput("wd.respReady1", 32'(req1_ready), 32'd0);
    checkOutput("wd.rsp0", 32'(rsp0_valid), 32'd1);
    checkOutput("wd.data", 32'(rsp_data), 32'hFF00);
    applyStimulus(1, 1'b0, 2'b00, 16'h1111, 16'h2222);
    tick();
    checkOutput("wd.idleBusy", 32'(busy), 32'd0);
    checkOutput("wd.idleReady1", 32'(req1_ready), 32'd0);
    tick();
    checkOutput("wd.noTransfer", 32'(busy), 32'd0);
    tick();
    checkOutput("wd.noRsp", 32'({rsp1_valid, rsp0_valid}), 32'd0);
    checkOutput("wd.dataHeld", 32'(rsp_data), 32'hFF00);

    $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
    $finish;
  end

endmodule
